// File: rtl/fec_encoder_tx.sv
// Hamming(16,11) SECDED encoder + MSB-first serializer; frame starts the clock after ack, 16*CYCLES_PER_BIT clocks per frame.
// One-word holding buffer: req is held off (no ack) while it is full; en low freezes acceptance and frame starts only.
module fec_encoder_tx #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req,
  input  logic [10:0] data_in,
  output logic        ack,
  output logic        busy,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_start
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [15:1]   cw_hi;
  logic [15:0]   cw;
  logic [15:0]   hold;
  logic          hold_valid;
  logic [14:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cyc_cnt;
  logic          accept;
  logic          bit_end;
  logic          frame_end;
  logic          load;

  // cw[i] sits at Hamming position i, so each parity bit covers the positions with that index bit set
  assign cw_hi[15:9] = data_in[10:4];
  assign cw_hi[8]    = ^data_in[10:4];
  assign cw_hi[7:5]  = data_in[3:1];
  assign cw_hi[4]    = ^{data_in[10:7], data_in[3:1]};
  assign cw_hi[3]    = data_in[0];
  assign cw_hi[2]    = ^{data_in[10:9], data_in[6:5], data_in[3:2], data_in[0]};
  assign cw_hi[1]    = ^{data_in[10], data_in[8], data_in[6], data_in[4], data_in[3], data_in[1], data_in[0]};
  assign cw          = {cw_hi, ^cw_hi};

  assign accept    = en & req & ~hold_valid & ~ack;
  assign bit_end   = (cyc_cnt == CYC_LAST);
  assign frame_end = (state == SHIFT) & bit_end & (bit_cnt == 4'd0);
  assign load      = hold_valid & en & ((state == IDLE) | frame_end);

  assign busy = hold_valid | tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      ack        <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= 4'd0;
      cyc_cnt    <= '0;
      tx_bit     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_start   <= 1'b0;
    end else begin
      ack      <= accept;
      tx_start <= 1'b0;

      // accept and load never coincide: accept needs an empty buffer, load a full one
      if (accept) begin
        hold       <= cw;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        state    <= SHIFT;
        shreg    <= hold[14:0];
        bit_cnt  <= 4'd15;
        cyc_cnt  <= '0;
        tx_bit   <= hold[15];
        tx_valid <= 1'b1;
        tx_start <= 1'b1;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          cyc_cnt <= '0;
          if (bit_cnt == 4'd0) begin
            state    <= IDLE;
            shreg    <= '0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
            shreg   <= {shreg[13:0], 1'b0};
            tx_bit  <= shreg[14];
          end
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fec_encoder_tx.sv
// Directed bench for fec_encoder_tx: a negedge receiver rebuilds frames and logs ack/start times;
// a small syndrome decoder cross-checks encoded words.
module tb_fec_encoder_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        req;
  logic [10:0] data_in;
  logic        ack;
  logic        busy;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_start;

  int checks   = 0;
  int failures = 0;

  int          cyc       = 0;
  int          vld_cnt   = 0;
  int          start_cnt = 0;
  int          glitch    = 0;
  int          rx_cnt    = 0;
  int          rx_t      = 0;
  logic [15:0] rx_sr     = '0;
  logic [15:0] rx_q[$];
  int          st_q[$];
  int          ack_t[$];

  fec_encoder_tx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .busy     (busy),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_start (tx_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: each bit must hold for CPB clocks; a frame is logged once all 16 bits arrive
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ack) ack_t.push_back(cyc);
    if (tx_valid) vld_cnt = vld_cnt + 1;
    if (tx_start) begin
      if (!tx_valid) glitch = glitch + 1;
      rx_cnt    = 0;
      rx_t      = cyc;
      start_cnt = start_cnt + 1;
    end
    if (tx_valid) begin
      if (rx_cnt % CPB == 0) rx_sr = {rx_sr[14:0], tx_bit};
      else if (tx_bit != rx_sr[0]) glitch = glitch + 1;
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 16 * CPB) begin
        rx_q.push_back(rx_sr);
        st_q.push_back(rx_t);
      end else if (rx_cnt > 16 * CPB) begin
        glitch = glitch + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic dec_ok(input logic [15:0] c, input logic [10:0] m);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i < 16; i++) if (c[i]) s = s ^ 4'(i);
    return (s == 4'd0) && !(^c) && ({c[15:9], c[7:5], c[3]} == m);
  endfunction

  task automatic wait_ack(input int n);
    int k;
    k = 0;
    while (ack_t.size() < n && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    check("ack_wait", (ack_t.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("frame_wait", (rx_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [10:0] m);
    int n0;
    n0 = ack_t.size();
    @(posedge clk); #1;
    req     = 1'b1;
    data_in = m;
    wait_ack(n0 + 1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] vm [3];
    logic [15:0] vc [3];
    logic [10:0] rw;
    logic        bad;
    int          v0, s0, a0;

    rst_n = 1'b0; en = 1'b1; req = 1'b0; data_in = '0;

    // Reset and idle
    @(negedge clk); #1;
    check("reset_outputs", {ack, busy, tx_bit, tx_valid, tx_start}, 5'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      bad = bad | ack | busy | tx_bit | tx_valid | tx_start;
    end
    check("idle_outputs", bad, 1'b0);

    // Single word: latency, pulse widths, frame length
    rx_q.delete(); st_q.delete(); ack_t.delete();
    v0 = vld_cnt; s0 = start_cnt;
    send_word(11'h001);
    wait_frames(1, 200);
    repeat (3) @(negedge clk); #1;
    check("single_cw", rx_q[0], 16'h000F);
    check("single_latency", st_q[0] - ack_t[0], 1);
    check("single_acks", ack_t.size(), 1);
    check("single_vld_clocks", vld_cnt - v0, 16 * CPB);
    check("single_starts", start_cnt - s0, 1);
    check("single_idle_after", {busy, tx_valid, tx_bit}, 3'd0);

    // Encoding vectors
    vm[0] = 11'h000; vc[0] = 16'h0000;
    vm[1] = 11'h7FF; vc[1] = 16'hFFFF;
    vm[2] = 11'h400; vc[2] = 16'h8117;
    for (int i = 0; i < 3; i++) begin
      rx_q.delete();
      send_word(vm[i]);
      wait_frames(1, 200);
      check("vector_cw", rx_q[0], vc[i]);
    end

    // Random words through the reference decoder
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      rw = 11'($urandom_range(0, 2047));
      send_word(rw);
      wait_frames(1, 200);
      check("random_decode", dec_ok(rx_q[0], rw), 1'b1);
    end

    // Back-to-back: second word accepted mid-frame, third held off until the first frame ends
    repeat (3) @(negedge clk);
    rx_q.delete(); st_q.delete(); ack_t.delete();
    v0 = vld_cnt;
    @(posedge clk); #1;
    req = 1'b1; data_in = 11'h400;
    wait_ack(1);
    @(posedge clk); #1;
    data_in = 11'h7FF;
    wait_ack(2);
    check("b2b_ack2_in_frame", tx_valid, 1'b1);
    @(posedge clk); #1;
    data_in = 11'h123;
    wait_ack(3);
    @(posedge clk); #1;
    req = 1'b0;
    wait_frames(3, 400);
    repeat (3) @(negedge clk); #1;
    check("b2b_cw0", rx_q[0], 16'h8117);
    check("b2b_cw1", rx_q[1], 16'hFFFF);
    check("b2b_cw2", rx_q[2], 16'h242B);
    check("b2b_ack2_time", ack_t[1] - st_q[0], 1);
    check("b2b_ack3_held", ack_t[2] - st_q[0], 16 * CPB + 1);
    check("b2b_gap01", st_q[1] - st_q[0], 16 * CPB);
    check("b2b_gap12", st_q[2] - st_q[1], 16 * CPB);
    check("b2b_vld_clocks", vld_cnt - v0, 3 * 16 * CPB);
    check("b2b_acks", ack_t.size(), 3);

    // req held across three edges while a frame shifts: exactly one capture
    rx_q.delete(); ack_t.delete();
    send_word(11'h555);
    req = 1'b1; data_in = 11'h0AA;
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    wait_frames(2, 400);
    repeat (100) @(negedge clk); #1;
    check("hold_acks", ack_t.size(), 2);
    check("hold_frames", rx_q.size(), 2);
    check("hold_decode0", dec_ok(rx_q[0], 11'h555), 1'b1);
    check("hold_decode1", dec_ok(rx_q[1], 11'h0AA), 1'b1);

    // Asynchronous reset at bit 7 with a word buffered
    rx_q.delete();
    send_word(11'h7FF);
    send_word(11'h400);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {ack, busy, tx_bit, tx_valid, tx_start}, 5'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    v0 = vld_cnt;
    repeat (60) @(negedge clk); #1;
    check("abort_no_resume", vld_cnt - v0, 0);
    check("abort_buffer_empty", busy, 1'b0);
    check("abort_no_frame", rx_q.size(), 0);
    send_word(11'h400);
    wait_frames(1, 200);
    check("abort_fresh_cw", rx_q[0], 16'h8117);

    // en dropped mid-frame: frame completes, buffered word waits for en
    repeat (3) @(negedge clk);
    rx_q.delete();
    send_word(11'h001);
    send_word(11'h7FF);
    en = 1'b0;
    wait_frames(1, 200);
    repeat (40) @(negedge clk); #1;
    check("en_frame_done", rx_q[0], 16'h000F);
    check("en_no_start", tx_valid, 1'b0);
    check("en_buffer_kept", busy, 1'b1);
    check("en_frame_count", rx_q.size(), 1);
    @(posedge clk); #1;
    en = 1'b1;
    wait_frames(2, 200);
    check("en_resume_cw", rx_q[1], 16'hFFFF);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    en = 1'b0; req = 1'b1; data_in = 11'h400;
    a0 = ack_t.size();
    repeat (10) @(negedge clk); #1;
    check("en_low_no_ack", ack_t.size() - a0, 0);
    check("en_low_idle", busy, 1'b0);
    req = 1'b0; en = 1'b1;

    check("stream_integrity", glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
